// File: rtl/audio_mixer_if.sv
// audio_mixer_if: channel sample/pan/volume inputs and the mixed-sample and DAC outputs of audio_mixer.
// master drives the sources; slave is the mixer itself.
interface audio_mixer_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic [CHANNELS*WIDTH-1:0] di;
  logic [2*CHANNELS-1:0]     pan;
  logic [4*CHANNELS-1:0]     vol;
  logic                      strobe;
  logic [WIDTH-1:0]          lsample;
  logic [WIDTH-1:0]          rsample;
  logic [1:0]                audio;

  modport master (output di, pan, vol, input strobe, lsample, rsample, audio);
  modport slave  (input di, pan, vol, output strobe, lsample, rsample, audio);
endinterface

// File: rtl/audio_mixer.sv
// audio_mixer: sequenced N-channel stereo mixer with saturating latch and two first-order delta-sigma DACs.
// Optional per-channel volume (gain (vol+1)/16, truncated) is enabled by defining AUDIO_MIXER_VOLUME_EN.
module audio_mixer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input logic          i_clock,
  input logic          i_reset,
  audio_mixer_if.slave io_mix
);
  localparam int IDX_W = $clog2(CHANNELS + 1);
  localparam int ACC_W = WIDTH + $clog2(CHANNELS) + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS);

  logic [IDX_W-1:0] r_idx;
  logic [ACC_W-1:0] r_lacc;
  logic [ACC_W-1:0] r_racc;
  logic [WIDTH-1:0] r_lsample;
  logic [WIDTH-1:0] r_rsample;
  logic             r_strobe;
  logic [WIDTH:0]   r_lsd;
  logic [WIDTH:0]   r_rsd;

  logic [WIDTH-1:0] w_di;
  logic [1:0]       w_pan;
  logic [WIDTH-1:0] w_scaled;
  logic [WIDTH-1:0] w_lsat;
  logic [WIDTH-1:0] w_rsat;

  always_comb begin
    w_di  = '0;
    w_pan = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_di  = io_mix.di[k*WIDTH +: WIDTH];
        w_pan = io_mix.pan[2*k +: 2];
      end
    end
  end

`ifdef AUDIO_MIXER_VOLUME_EN
  logic [3:0]       w_vol;
  logic [WIDTH+3:0] w_product;

  always_comb begin
    w_vol = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_idx == IDX_W'(k)) w_vol = io_mix.vol[4*k +: 4];
    end
  end

  // (vol+1) never exceeds 16, so the product fits in WIDTH+4 bits
  assign w_product = (WIDTH+4)'(w_di) * (WIDTH+4)'({1'b0, w_vol} + 5'd1);
  assign w_scaled  = WIDTH'(w_product >> 4);
`else
  logic w_unused_vol;
  assign w_unused_vol = ^io_mix.vol;
  assign w_scaled     = w_di;
`endif

  assign w_lsat = (|r_lacc[ACC_W-1:WIDTH]) ? '1 : r_lacc[WIDTH-1:0];
  assign w_rsat = (|r_racc[ACC_W-1:WIDTH]) ? '1 : r_racc[WIDTH-1:0];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_idx     <= '0;
      r_lacc    <= '0;
      r_racc    <= '0;
      r_lsample <= '0;
      r_rsample <= '0;
      r_strobe  <= 1'b0;
      r_lsd     <= '0;
      r_rsd     <= '0;
    end else begin
      if (r_idx == LAST) begin
        r_idx     <= '0;
        r_lacc    <= '0;
        r_racc    <= '0;
        r_lsample <= w_lsat;
        r_rsample <= w_rsat;
        r_strobe  <= 1'b1;
      end else begin
        r_idx    <= r_idx + 1'b1;
        r_lacc   <= r_lacc + (w_pan[0] ? ACC_W'(w_scaled) : '0);
        r_racc   <= r_racc + (w_pan[1] ? ACC_W'(w_scaled) : '0);
        r_strobe <= 1'b0;
      end
      // the carry out of the WIDTH-bit phase accumulator is the DAC bit
      r_lsd <= {1'b0, r_lsd[WIDTH-1:0]} + {1'b0, r_lsample};
      r_rsd <= {1'b0, r_rsd[WIDTH-1:0]} + {1'b0, r_rsample};
    end
  end

  assign io_mix.strobe  = r_strobe;
  assign io_mix.lsample = r_lsample;
  assign io_mix.rsample = r_rsample;
  assign io_mix.audio   = {r_rsd[WIDTH], r_lsd[WIDTH]};
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: directed-vector bench for audio_mixer (CHANNELS=4, WIDTH=8).
// Expected values are hand-computed; volume expectation follows AUDIO_MIXER_VOLUME_EN.
module tb_audio_mixer;
  localparam int CH = 4;
  localparam int W  = 8;
`ifdef AUDIO_MIXER_VOLUME_EN
  localparam logic [W-1:0] VOL7_EXP = 8'h40;
`else
  localparam logic [W-1:0] VOL7_EXP = 8'h80;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  audio_mixer_if #(.CHANNELS(CH), .WIDTH(W)) mix ();

  audio_mixer #(.CHANNELS(CH), .WIDTH(W)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .io_mix  (mix)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // returns the number of cycles until strobe is seen; 20 means it never came
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!mix.strobe && n < 20);
  endtask

  task automatic settle(input string tag);
    int n;
    wait_strobe(n);
    wait_strobe(n);
    chk({tag, "_period"}, n, 5);
  endtask

  task automatic density(output int l, output int r);
    l = 0;
    r = 0;
    repeat (4) step();
    repeat (256) begin
      step();
      l += int'(mix.audio[0]);
      r += int'(mix.audio[1]);
    end
  endtask

  initial begin
    int n, l, r;
    mix.di  = '0;
    mix.pan = '0;
    mix.vol = '1;

    repeat (3) step();
    chk("rst_lsample", mix.lsample, 0);
    chk("rst_rsample", mix.rsample, 0);
    chk("rst_strobe",  mix.strobe,  0);
    chk("rst_audio",   mix.audio,   0);

    rst_n = 1'b1;
    wait_strobe(n);
    chk("first_strobe", n, 5);
    step();
    chk("strobe_width", mix.strobe, 0);
    wait_strobe(n);
    chk("strobe_period", n, 4);

    // single channel, unity volume
    mix.di  = 32'h0000_0040;
    mix.pan = 8'b0000_0011;
    mix.vol = 16'hFFFF;
    settle("ch0");
    chk("ch0_l", mix.lsample, 8'h40);
    chk("ch0_r", mix.rsample, 8'h40);
    density(l, r);
    chk("ch0_dens_l", l, 64);
    chk("ch0_dens_r", r, 64);

    // all channels: 4*0x80 saturates
    mix.di  = 32'h8080_8080;
    mix.pan = 8'hFF;
    settle("sat");
    chk("sat_l", mix.lsample, 8'hFF);
    chk("sat_r", mix.rsample, 8'hFF);
    density(l, r);
    chk("sat_dens_l", l, 255);
    chk("sat_dens_r", r, 255);

    // ch1 left only, ch2 right only
    mix.di  = 32'h0020_3000;
    mix.pan = 8'b0010_0100;
    settle("split");
    chk("split_l", mix.lsample, 8'h30);
    chk("split_r", mix.rsample, 8'h20);
    density(l, r);
    chk("split_dens_l", l, 48);
    chk("split_dens_r", r, 32);

    // volume 7 on ch0
    mix.di  = 32'h0000_0080;
    mix.pan = 8'b0000_0011;
    mix.vol = 16'hFFF7;
    settle("vol");
    chk("vol_l", mix.lsample, VOL7_EXP);
    chk("vol_r", mix.rsample, VOL7_EXP);

    // reset in the middle of a frame
    mix.di  = 32'h0000_0010;
    mix.vol = 16'hFFFF;
    settle("mid");
    chk("mid_pre_l", mix.lsample, 8'h10);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_l",      mix.lsample, 0);
    chk("mid_rst_r",      mix.rsample, 0);
    chk("mid_rst_strobe", mix.strobe,  0);
    chk("mid_rst_audio",  mix.audio,   0);
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("mid_nopartial_l", mix.lsample, 0);
    chk("mid_nopartial_s", mix.strobe,  0);
    step();
    chk("mid_strobe", mix.strobe,  1);
    chk("mid_l",      mix.lsample, 8'h10);
    chk("mid_r",      mix.rsample, 8'h10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
